// File: rtl/sopc_data_bus_if.sv
// ----------------------------------------------------------------------------
// sopc_data_bus_if
//   Signal bundle for the SOPC data-side interconnect. It carries both sides of
//   the bus: the CPU data port (m_*) and the shared slave lines (s_*).
//
//   Handshake: the master raises m_ce with m_we/m_addr/m_sel/m_wdata stable and
//   keeps them stable while m_stall is high. The cycle in which m_stall is low
//   (RESP) is the single completion cycle; m_rdata/m_err are valid only then.
//   A slave completes by raising s_ack[i] while its s_ce[i] is high; acks on
//   unselected slaves, or outside an active request, are ignored.
//
//   Modports:
//     master - the environment: CPU request side plus the slave responders
//     slave  - the interconnect that answers the CPU and drives the slaves
// ----------------------------------------------------------------------------
interface sopc_data_bus_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                         m_ce;
    logic                         m_we;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W/8-1:0]          m_sel;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_stall;
    logic                         m_err;

    logic [NUM_SLAVES-1:0]        s_ce;
    logic                         s_we;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W/8-1:0]          s_sel;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ack;

    modport master (
        output m_ce, m_we, m_addr, m_sel, m_wdata, s_rdata, s_ack,
        input  m_rdata, m_stall, m_err, s_ce, s_we, s_addr, s_sel, s_wdata
    );

    modport slave (
        input  m_ce, m_we, m_addr, m_sel, m_wdata, s_rdata, s_ack,
        output m_rdata, m_stall, m_err, s_ce, s_we, s_addr, s_sel, s_wdata
    );
endinterface

// File: rtl/sopc_data_bus.sv
// ----------------------------------------------------------------------------
// sopc_data_bus
//   Data-side interconnect between the CPU data port and NUM_SLAVES
//   memory-mapped slaves. The top REGION_BITS address bits select the slave;
//   slaves may insert wait states by delaying s_ack; an unmapped region or an
//   access that is not acked within TIMEOUT cycles completes with m_err=1.
//
//   Ports:
//     clk            clock, rising edge
//     rst            asynchronous active-low reset
//     bus            sopc_data_bus_if.slave (m_* CPU side, s_* slave side)
//     dbg_state_o    FSM state: 0=IDLE, 1=REQ, 2=RESP
//   Optional (macro SOPC_DATA_BUS_PERF_EN):
//     perf_clr       synchronous clear of both counters (wins over increment)
//     perf_acc_cnt   completed accesses (+1 per RESP cycle), saturating
//     perf_wait_cnt  cycles spent in REQ, saturating
// ----------------------------------------------------------------------------
module sopc_data_bus #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLAVES  = 4,
    parameter int REGION_BITS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SOPC_DATA_BUS_PERF_EN
    input  logic                perf_clr,
    output logic [31:0]         perf_acc_cnt,
    output logic [31:0]         perf_wait_cnt,
`endif
    output logic [1:0]          dbg_state_o,
    sopc_data_bus_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int SEL_W = DATA_W / 8;

    state_t                 state_q, state_d;
    logic [NUM_SLAVES-1:0]  s_ce_q, s_ce_d;
    logic                   s_we_q, s_we_d;
    logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
    logic [SEL_W-1:0]       s_sel_q, s_sel_d;
    logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
    logic                   m_err_q, m_err_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [REGION_BITS-1:0] req_idx;
    logic                   req_valid;
    logic                   ack_hit;
    logic [DATA_W-1:0]      ack_rdata;
    logic                   timeout_hit;

    assign req_idx   = bus.m_addr[ADDR_W-1 -: REGION_BITS];
    assign req_valid = 32'(req_idx) < NUM_SLAVES;

    // Only the selected slave's ack counts; s_ce_q is one-hot in REQ, so the
    // selected slave's read data falls out of the same scan.
    always_comb begin
        ack_hit   = 1'b0;
        ack_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_ce_q[i] && bus.s_ack[i]) begin
                ack_hit   = 1'b1;
                ack_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The counter is cleared on entry to REQ, so the Nth REQ cycle sees N-1.
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        s_ce_d    = s_ce_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_sel_d   = s_sel_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.m_ce) begin
                    s_we_d    = bus.m_we;
                    s_addr_d  = bus.m_addr;
                    s_sel_d   = bus.m_sel;
                    s_wdata_d = bus.m_wdata;
                    cnt_d     = '0;
                    if (req_valid) begin
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            s_ce_d[i] = (32'(req_idx) == i);
                        end
                        state_d = REQ;
                    end else begin
                        s_ce_d    = '0;
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        state_d   = RESP;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                // Ack is checked first so it wins over a coincident timeout.
                if (ack_hit) begin
                    m_rdata_d = s_we_q ? '0 : ack_rdata;
                    m_err_d   = 1'b0;
                    s_ce_d    = '0;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    s_ce_d    = '0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                m_rdata_d = '0;
                m_err_d   = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            s_ce_q    <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_sel_q   <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_ce_q    <= s_ce_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_sel_q   <= s_sel_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.s_ce    = s_ce_q;
    assign bus.s_we    = s_we_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_sel   = s_sel_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_err   = m_err_q;
    // Low only in RESP, which is how the master sees completion.
    assign bus.m_stall = bus.m_ce && (state_q != RESP);
    assign dbg_state_o = state_q;

`ifdef SOPC_DATA_BUS_PERF_EN
    logic [31:0] acc_cnt_q, wait_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else if (perf_clr) begin
            acc_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            if ((state_q == RESP) && (acc_cnt_q != '1)) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            if ((state_q == REQ) && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign perf_acc_cnt  = acc_cnt_q;
    assign perf_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_sopc_data_bus.sv
module tb_sopc_data_bus;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int NUM_SLAVES  = 4;
    localparam int REGION_BITS = 4;
    localparam int TIMEOUT     = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] dbg_state;
    int n_vec = 0;
    int n_err = 0;

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_err_q[$];
    int                exp_cyc_q[$];
    logic [DATA_W-1:0] slave_data [NUM_SLAVES];

    sopc_data_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES)) bus_if ();

`ifdef SOPC_DATA_BUS_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_acc_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    sopc_data_bus #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
        .REGION_BITS(REGION_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SOPC_DATA_BUS_PERF_EN
        .perf_clr(perf_clr),
        .perf_acc_cnt(perf_acc_cnt),
        .perf_wait_cnt(perf_wait_cnt),
`endif
        .dbg_state_o(dbg_state),
        .bus(bus_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_slaves();
        for (int i = 0; i < NUM_SLAVES; i++) begin
            bus_if.s_rdata[i*DATA_W +: DATA_W] = slave_data[i];
        end
    endtask

    // ---------------- driver + reference model ----------------
    // One full access: the slave acks in REQ cycle waits+1 (never if that is
    // past the timeout). Unselected slaves get random acks throughout.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata, input int waits);
        int          idx;
        logic        dec_err, tmo;
        logic [3:0]  onehot;
        int          req_cyc;
        logic        done;

        idx     = int'(addr[31:28]);
        dec_err = (idx >= NUM_SLAVES);
        tmo     = !dec_err && (waits >= TIMEOUT);
        onehot  = dec_err ? 4'b0000 : 4'(1 << idx);
        exp_err_q.push_back(dec_err || tmo);
        exp_q.push_back((dec_err || tmo || we) ? 32'h0 : slave_data[idx]);
        exp_cyc_q.push_back(dec_err ? 0 : (tmo ? TIMEOUT : waits + 1));

        @(posedge clk); #1;
        load_slaves();
        bus_if.m_ce    = 1'b1;
        bus_if.m_we    = we;
        bus_if.m_addr  = addr;
        bus_if.m_sel   = sel;
        bus_if.m_wdata = wdata;
        bus_if.s_ack   = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("idle_stall", bus_if.m_stall, 1);
        check("idle_s_ce", bus_if.s_ce, 0);
        @(posedge clk); #1;

        req_cyc = 0;
        done    = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_if.s_ack = 4'($urandom_range(0, 15)) & ~onehot;
            if (req_cyc == waits) bus_if.s_ack = bus_if.s_ack | onehot;
            @(negedge clk);
            if (!bus_if.m_stall) begin
                done = 1'b1;
            end else begin
                req_cyc++;
                check("req_s_ce", bus_if.s_ce, onehot);
                @(posedge clk); #1;
            end
        end

        check("completed", done, 1);
        if (done) begin
            check("req_cycles", req_cyc, exp_cyc_q.pop_front());
            check("m_rdata", bus_if.m_rdata, exp_q.pop_front());
            check("m_err", bus_if.m_err, exp_err_q.pop_front());
            check("resp_s_ce", bus_if.s_ce, 0);
            check("s_addr", bus_if.s_addr, addr);
            check("s_we", bus_if.s_we, we);
            check("s_sel", bus_if.s_sel, sel);
            check("s_wdata", bus_if.s_wdata, wdata);
            bus_if.m_ce  = 1'b0;
            bus_if.s_ack = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("clr_rdata", bus_if.m_rdata, 0);
            check("clr_err", bus_if.m_err, 0);
            check("idle_s_ce_after", bus_if.s_ce, 0);
        end else begin
            void'(exp_cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            bus_if.m_ce = 1'b0;
        end
        bus_if.s_ack = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
`ifdef SOPC_DATA_BUS_PERF_EN
        int exp_wait;
        perf_clr = 1'b0;
`endif
        rst            = 1'b0;
        bus_if.m_ce    = 1'b0;
        bus_if.m_we    = 1'b0;
        bus_if.m_addr  = '0;
        bus_if.m_sel   = '0;
        bus_if.m_wdata = '0;
        bus_if.s_ack   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) slave_data[i] = $urandom;
        load_slaves();

        repeat (2) @(negedge clk);
        check("rst_state", dbg_state, 2'd0);
        check("rst_s_ce", bus_if.s_ce, 0);
        check("rst_s_we", bus_if.s_we, 0);
        check("rst_s_addr", bus_if.s_addr, 0);
        check("rst_s_sel", bus_if.s_sel, 0);
        check("rst_s_wdata", bus_if.s_wdata, 0);
        check("rst_m_rdata", bus_if.m_rdata, 0);
        check("rst_m_err", bus_if.m_err, 0);
        rst = 1'b1;

        // zero-wait read of slave 0
        slave_data[0] = 32'hDEADBEEF;
        do_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0);
        // write to slave 2 with three wait states
        do_access(1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678, 3);
        // unmapped region
        do_access(1'b0, 32'h7000_0000, 4'hF, 32'h0, 0);
        // slave 1 never acks, then a normal access
        do_access(1'b0, 32'h1000_0000, 4'hF, 32'h0, 100);
        do_access(1'b0, 32'h1000_0008, 4'hF, 32'h0, 1);
        // ack in the same cycle as the timeout, and one cycle too late
        do_access(1'b0, 32'h3000_0020, 4'hF, 32'h0, TIMEOUT - 1);
        do_access(1'b0, 32'h3000_0024, 4'hF, 32'h0, TIMEOUT);

        // asynchronous reset in the middle of a slave-3 request
        @(posedge clk); #1;
        bus_if.m_ce   = 1'b1;
        bus_if.m_we   = 1'b0;
        bus_if.m_addr = 32'h3000_0000;
        bus_if.s_ack  = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("prerst_s_ce", bus_if.s_ce, 4'b1000);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_s_ce", bus_if.s_ce, 0);
        check("arst_state", dbg_state, 2'd0);
        bus_if.m_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        slave_data[0] = 32'hDEADBEEF;
        do_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0);

        // randomized accesses
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NUM_SLAVES; i++) slave_data[i] = $urandom;
            do_access(1'($urandom_range(0, 1)),
                      {4'($urandom_range(0, 7)), 28'($urandom)},
                      4'($urandom_range(0, 15)), $urandom,
                      int'($urandom_range(0, 10)));
        end

`ifdef SOPC_DATA_BUS_PERF_EN
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        check("perf_clr_acc", perf_acc_cnt, 0);
        check("perf_clr_wait", perf_wait_cnt, 0);
        exp_wait = 0;
`endif
`ifdef SOPC_DATA_BUS_PERF_EN
        for (int k = 0; k < 3; k++) begin
            int w;
            w = (k == 0) ? 0 : ((k == 1) ? 2 : 5);
            exp_wait += w + 1;
            do_access(1'b0, 32'h1000_0000, 4'hF, 32'h0, w);
        end
        check("perf_acc", perf_acc_cnt, 3);
        check("perf_wait", perf_wait_cnt, exp_wait);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        check("perf_clr2_acc", perf_acc_cnt, 0);
        check("perf_clr2_wait", perf_wait_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

endmodule
